sys_skew_feeder: RTL and testbench
==================================

Name: sys_skew_feeder

Overview:
- Parametrised activation feeder for the systolic array.
- Buffers up to DEPTH column vectors, each SYS_ROWS elements of A_BITWIDTH bits, loaded one vector per cycle.
- On start, streams the stored vectors into the array rows with diagonal skew: row r is delayed r cycles.
- Successor to fixed compile-time matrix sizing: stream length is set at runtime by fill count, and a keep mode replays the buffer without reloading.

Parameters:
- SYS_ROWS, 5, number of array rows fed (elements per vector).
- A_BITWIDTH, 8, bits per activation element.
- DEPTH, 16, vector capacity of the buffer.
- CNT_W, $clog2(DEPTH+1), width of the fill counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write vector offered.
- wr_ready  out  1  feeder can accept a vector.
- wr_data  in  SYS_ROWS*A_BITWIDTH  vector; element r at [r*A_BITWIDTH +: A_BITWIDTH].
- start  in  1  begin streaming the stored vectors.
- keep  in  1  sampled with start; 1 = retain contents after stream.
- clr  in  1  synchronous flush/abort.
- busy  out  1  stream in progress.
- done  out  1  one-cycle pulse at stream end.
- count  out  CNT_W  number of stored vectors.
- a_out  out  SYS_ROWS*A_BITWIDTH  skewed row data to the array; row r at [r*A_BITWIDTH +: A_BITWIDTH].
- a_valid  out  SYS_ROWS  per-row valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state IDLE; count, pointers, busy, done, a_valid, a_out = 0; wr_ready = 0 while in reset.
  - Buffer contents need not be cleared.
- States:
  - IDLE: wr_ready = (count < DEPTH). A write is accepted on wr_valid && wr_ready; it is stored at index count, then count increments.
  - IDLE, start with count>=1: enter STREAM, latch n=count and keep. A write accepted on the same edge is included (n = count+1).
  - IDLE, start with count==0 (and no write that cycle): ignored; no busy, no done.
  - STREAM: wr_ready=0; wr_valid and start are ignored.
- Streaming timing, with the start edge as edge 0:
  - Vector k, element r is presented on a_out row r with a_valid[r]=1 after edge k+1+r, for k = 0..n-1.
  - Row r is zero with a_valid[r]=0 outside that window.
  - All outputs are registered; there is no combinational path from inputs to a_out.
  - busy=1 from after edge 0 through edge n+SYS_ROWS-1.
  - After edge n+SYS_ROWS: done=1 for exactly one cycle, busy=0, state returns to IDLE.
  - On that same edge, count is cleared to 0 if the latched keep=0, and left unchanged if keep=1.
  - With keep=1, start may be reissued in the first IDLE cycle after done and replays identical data. Loading further vectors first appends them at index count.
- clr (sync, any state, highest priority):
  - count=0, state IDLE, a_valid=0, a_out=0, busy=0.
  - No done pulse; a write offered in the same cycle is dropped.
- Full (count==DEPTH): wr_ready=0; start is still accepted.
- Skew: row r uses an r-stage delay line; row 0 has zero added delay. Delay lines flush with zeros and valid 0 after the last vector.

Decomposition:
- Shared Config package holds:
  - a_vec_t: a packed array [SYS_ROWS] of logic [A_BITWIDTH-1:0].
  - the DEPTH default (input_buffer_depth).
  - the count-width helper function.
- One sub-module, skew_delay_line:
  - Parameters WIDTH and STAGES; input and output are data plus valid; async active-low reset clears it; sync clr input.
  - Instantiated per row with STAGES=r.
  - STAGES=0 is a pass-through of the already-registered read stage.

Test Plan:
All scenarios use defaults SYS_ROWS=5, DEPTH=16. Vector k element r = 16*k + r.
- Load 3 vectors, then start with keep=0:
  - row0 shows 0x00, 0x10, 0x20 after edges 1-3.
  - row4 shows 0x04, 0x14, 0x24 after edges 5-7.
  - a_valid matches those windows exactly.
  - done pulses after edge 8; count = 0 afterwards.
- Fill 16 vectors:
  - wr_ready drops after the 16th; a 17th wr_valid is not accepted; count = 16.
  - start streams 16 vectors; done after edge 21.
- keep=1 with 2 vectors:
  - After done, count = 2.
  - A second start produces a byte-identical row sequence and done again after edge 7.
- start with count = 0 → no busy, no done, outputs stay 0.
- Same-cycle write and start with count = 2 → n = 3; done after edge 8.
- Abort paths:
  - clr asserted after edge 3 of a 4-vector stream: next cycle a_valid = 0, busy = 0, count = 0, no done.
  - rst_n pulsed low mid-stream: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sys_skew_feeder_pkg.sv
// Shared configuration for the systolic activation feeder: default sizes,
// vector type, FSM state encoding and the fill-counter width helper.
package sys_skew_feeder_pkg;

    localparam int SYS_ROWS_DEF       = 5;
    localparam int A_BITWIDTH_DEF     = 8;
    localparam int INPUT_BUFFER_DEPTH = 16;

    typedef logic [SYS_ROWS_DEF-1:0][A_BITWIDTH_DEF-1:0] a_vec_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } feeder_state_t;

    // A counter that must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sys_skew_feeder_if.sv
// Load/stream interface of the skew feeder; the master side loads vectors
// and launches streams, the slave side is the feeder itself.
interface sys_skew_feeder_if #(
    parameter int SYS_ROWS   = sys_skew_feeder_pkg::SYS_ROWS_DEF,
    parameter int A_BITWIDTH = sys_skew_feeder_pkg::A_BITWIDTH_DEF,
    parameter int DEPTH      = sys_skew_feeder_pkg::INPUT_BUFFER_DEPTH,
    parameter int CNT_W      = sys_skew_feeder_pkg::cnt_width(DEPTH)
) ();

    // Handshake: a vector transfers on a rising clock edge where wr_valid and
    // wr_ready are both 1 (and clr is 0); the master holds wr_data stable while
    // wr_valid is high, and wr_ready never depends combinationally on wr_valid.
    logic                           wr_valid;
    logic                           wr_ready;
    logic [SYS_ROWS*A_BITWIDTH-1:0] wr_data;
    logic                           start;
    logic                           keep;
    logic                           clr;
    logic                           busy;
    logic                           done;
    logic [CNT_W-1:0]               count;
    logic [SYS_ROWS*A_BITWIDTH-1:0] a_out;
    logic [SYS_ROWS-1:0]            a_valid;
    sys_skew_feeder_pkg::feeder_state_t dbg_state;

    modport master (
        output wr_valid, wr_data, start, keep, clr,
        input  wr_ready, busy, done, count, a_out, a_valid, dbg_state
    );

    modport slave (
        input  wr_valid, wr_data, start, keep, clr,
        output wr_ready, busy, done, count, a_out, a_valid, dbg_state
    );

endinterface

// File: rtl/sys_skew_feeder_skew_delay_line.sv
// Fixed-length data+valid delay line used to skew one array row; zero
// stages degenerates to a wire on top of the feeder's registered read stage.
module skew_delay_line #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    generate
        if (STAGES == 0) begin : g_pass
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, rst_n, i_clr};
            assign o_data      = i_data;
            assign o_valid     = i_valid;
        end else begin : g_shift
            logic [STAGES-1:0][WIDTH-1:0] r_data;
            logic [STAGES-1:0]            r_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= '0;
                end else if (i_clr) begin
                    r_data  <= '0;
                    r_valid <= '0;
                end else begin
                    r_data[0]  <= i_data;
                    r_valid[0] <= i_valid;
                    for (int s = 1; s < STAGES; s++) begin
                        r_data[s]  <= r_data[s-1];
                        r_valid[s] <= r_valid[s-1];
                    end
                end
            end

            assign o_data  = r_data[STAGES-1];
            assign o_valid = r_valid[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sys_skew_feeder.sv
// Activation feeder: buffers column vectors, then streams them into the
// systolic array rows with a diagonal skew of r cycles on row r.
module sys_skew_feeder
    import sys_skew_feeder_pkg::*;
#(
    parameter int SYS_ROWS   = SYS_ROWS_DEF,
    parameter int A_BITWIDTH = A_BITWIDTH_DEF,
    parameter int DEPTH      = INPUT_BUFFER_DEPTH,
    parameter int CNT_W      = cnt_width(DEPTH)
) (
    input logic          clk,
    input logic          rst_n,
    sys_skew_feeder_if.slave bus
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STEP_W = $clog2(DEPTH + SYS_ROWS + 1);

    typedef logic [SYS_ROWS-1:0][A_BITWIDTH-1:0] row_vec_t;

    feeder_state_t       r_state;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_n;
    logic                r_keep;
    logic                r_busy;
    logic                r_done;
    logic [STEP_W-1:0]   r_step;
    row_vec_t            r_rd_data;
    logic                r_rd_valid;
    row_vec_t            r_buf [DEPTH];

    logic                w_wr_ready;
    logic                w_wr_fire;
    logic                w_start_ok;
    logic [STEP_W-1:0]   w_last_step;
    row_vec_t            w_row_data;
    logic [SYS_ROWS-1:0] w_row_valid;

    assign w_wr_ready  = rst_n && (r_state == ST_IDLE) && (r_count < CNT_W'(DEPTH));
    assign w_wr_fire   = bus.wr_valid && w_wr_ready && !bus.clr;
    assign w_start_ok  = bus.start && ((r_count != '0) || w_wr_fire);
    // r_step counts edges after the start edge minus one; the last one flushes row SYS_ROWS-1.
    assign w_last_step = STEP_W'(r_n) + STEP_W'(SYS_ROWS - 1);

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_buf[r_count[IDX_W-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_n        <= '0;
            r_keep     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_step     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (bus.clr) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_step     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_fire) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (w_start_ok) begin
                        r_state <= ST_STREAM;
                        r_n     <= r_count + CNT_W'(w_wr_fire);
                        r_keep  <= bus.keep;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (r_step < STEP_W'(r_n)) begin
                        r_rd_data  <= r_buf[r_step[IDX_W-1:0]];
                        r_rd_valid <= 1'b1;
                    end
                    if (r_step == w_last_step) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (!r_keep) begin
                            r_count <= '0;
                        end
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < SYS_ROWS; r++) begin : g_row
        skew_delay_line #(
            .WIDTH  (A_BITWIDTH),
            .STAGES (r)
        ) u_dly (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (bus.clr),
            .i_data  (r_rd_data[r]),
            .i_valid (r_rd_valid),
            .o_data  (w_row_data[r]),
            .o_valid (w_row_valid[r])
        );
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.count     = r_count;
    assign bus.a_out     = w_row_data;
    assign bus.a_valid   = w_row_valid;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sys_skew_feeder.sv
// Self-checking bench for sys_skew_feeder: hand-derived vector table, directed
// corner sequences and randomized traffic against a queue-based stream model.
module tb_sys_skew_feeder;
    import sys_skew_feeder_pkg::*;

    localparam int ROWS  = 5;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int VEC_W = ROWS * AW;
    localparam int OBS_W = 3 + CW + ROWS + VEC_W;
    localparam int REC_W = ROWS + VEC_W;

    logic clk;
    logic rst_n;

    sys_skew_feeder_if #(.SYS_ROWS(ROWS), .A_BITWIDTH(AW), .DEPTH(DEPTH), .CNT_W(CW)) bus ();

    sys_skew_feeder #(.SYS_ROWS(ROWS), .A_BITWIDTH(AW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [OBS_W-1:0] exp_q[$];

    // Reference model: buffer contents, the vectors of the current stream and
    // the number of edges elapsed since its start edge.
    logic [VEC_W-1:0] m_buf[$];
    logic [VEC_W-1:0] m_str[$];
    int   m_j      = 0;
    bit   m_stream = 0;
    bit   m_keep   = 0;
    bit   m_done   = 0;

    logic             g_done;
    bit               g_rec = 0;
    logic [REC_W-1:0] rec_q[$];
    logic [REC_W-1:0] seq1[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp_v);
        end
    endtask

    function automatic logic [VEC_W-1:0] vec_of(input int k);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*AW +: AW] = 8'((16 * k + r) & 255);
        return v;
    endfunction

    function automatic logic [OBS_W-1:0] obs_now();
        return {bus.wr_ready, bus.busy, bus.done, bus.count, bus.a_valid, bus.a_out};
    endfunction

    // Row r after edge j carries vector j-1-r when that index is inside the stream.
    function automatic logic [OBS_W-1:0] m_obs();
        logic [ROWS-1:0]  val;
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] t;
        int k;
        val = '0;
        a   = '0;
        for (int r = 0; r < ROWS; r++) begin
            k = m_j - 1 - r;
            if (k >= 0 && k < m_str.size()) begin
                t = m_str[k];
                val[r] = 1'b1;
                a[r*AW +: AW] = t[r*AW +: AW];
            end
        end
        return {(!m_stream && (m_buf.size() < DEPTH)), m_stream, m_done,
                CW'(m_buf.size()), val, a};
    endfunction

    function automatic void m_edge(input logic wv, input logic [VEC_W-1:0] wd,
                                   input logic st, input logic kp, input logic cl);
        if (cl) begin
            m_buf.delete();
            m_str.delete();
            m_stream = 0;
            m_done   = 0;
            m_j      = 0;
        end else if (m_stream) begin
            m_j++;
            m_done = 0;
            if (m_j == m_str.size() + ROWS) begin
                m_stream = 0;
                m_done   = 1;
                if (!m_keep) m_buf.delete();
            end
        end else begin
            m_done = 0;
            if (wv && m_buf.size() < DEPTH) m_buf.push_back(wd);
            if (st && m_buf.size() > 0) begin
                m_str    = m_buf;
                m_stream = 1;
                m_keep   = kp;
                m_j      = 0;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_raw(input logic wv, input logic [VEC_W-1:0] wd,
                             input logic st, input logic kp, input logic cl);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.start    = st;
        bus.keep     = kp;
        bus.clr      = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic wv, input logic [VEC_W-1:0] wd,
                         input logic st, input logic kp, input logic cl);
        logic [OBS_W-1:0] exp_v;
        m_edge(wv, wd, st, kp, cl);
        exp_q.push_back(m_obs());
        drive_raw(wv, wd, st, kp, cl);
        exp_v = exp_q.pop_front();
        chk("cycle_obs", 64'(obs_now()), 64'(exp_v));
        g_done = bus.done;
        if (g_rec) rec_q.push_back({bus.a_valid, bus.a_out});
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_done(input int budget, output int done_at);
        done_at = -1;
        for (int i = 1; i <= budget; i++) begin
            idle();
            if (g_done) begin
                done_at = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.keep     = 1'b0;
        bus.clr      = 1'b0;
        #1;
        chk("reset_outputs", 64'(obs_now()), 64'(0));
        chk("reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));
        m_buf.delete();
        m_str.delete();
        m_stream = 0;
        m_done   = 0;
        m_j      = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          wv;
        int            wk;
        logic          st;
        logic          kp;
        logic          cl;
        logic [CW-1:0] e_count;
        logic          e_busy;
        logic          e_done;
        logic [ROWS-1:0] e_valid;
        logic [AW-1:0] e_r0;
        logic [AW-1:0] e_r4;
    } tv_t;

    tv_t tv[$];

    function automatic tv_t mk(input logic wv, input int wk, input logic st, input logic kp,
                               input logic cl, input int cnt, input logic b, input logic d,
                               input logic [ROWS-1:0] v, input logic [AW-1:0] r0,
                               input logic [AW-1:0] r4);
        tv_t t;
        t.wv = wv; t.wk = wk; t.st = st; t.kp = kp; t.cl = cl;
        t.e_count = CW'(cnt); t.e_busy = b; t.e_done = d;
        t.e_valid = v; t.e_r0 = r0; t.e_r4 = r4;
        return t;
    endfunction

    initial begin
        int done_at;
        bit same;
        bit seen;
        logic [63:0] got_t;
        logic [63:0] exp_t;

        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.keep     = 1'b0;
        bus.clr      = 1'b0;
        do_reset();

        // Load 3, stream with keep=0, then a start on an empty buffer.
        tv.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 8'h00, 8'h00));
        tv.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0, 5'b00000, 8'h00, 8'h00));
        tv.push_back(mk(1, 2, 0, 0, 0, 3, 0, 0, 5'b00000, 8'h00, 8'h00));
        tv.push_back(mk(0, 0, 1, 0, 0, 3, 1, 0, 5'b00000, 8'h00, 8'h00));
        tv.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 5'b00001, 8'h00, 8'h00));
        tv.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 5'b00011, 8'h10, 8'h00));
        tv.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 5'b00111, 8'h20, 8'h00));
        tv.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 5'b01110, 8'h00, 8'h00));
        tv.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 5'b11100, 8'h00, 8'h04));
        tv.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 5'b11000, 8'h00, 8'h14));
        tv.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 5'b10000, 8'h00, 8'h24));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 8'h00, 8'h00));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 8'h00, 8'h00));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 8'h00, 8'h00));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 8'h00, 8'h00));

        for (int i = 0; i < tv.size(); i++) begin
            drive_raw(tv[i].wv, tv[i].wv ? vec_of(tv[i].wk) : '0, tv[i].st, tv[i].kp, tv[i].cl);
            got_t = 64'({bus.count, bus.busy, bus.done, bus.a_valid,
                          bus.a_out[0 +: AW], bus.a_out[4*AW +: AW]});
            exp_t = 64'({tv[i].e_count, tv[i].e_busy, tv[i].e_done, tv[i].e_valid,
                          tv[i].e_r0, tv[i].e_r4});
            chk($sformatf("table[%0d]", i), got_t, exp_t);
        end

        do_reset();

        // Fill to capacity; the 17th offer must be refused, then stream all 16.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, vec_of(k), 1'b0, 1'b0, 1'b0);
        chk("full_ready", 64'(bus.wr_ready), 64'(0));
        cycle(1'b1, vec_of(16), 1'b0, 1'b0, 1'b0);
        chk("full_count", 64'(bus.count), 64'(16));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        wait_done(40, done_at);
        chk("fill_done_edge", 64'(done_at), 64'(21));
        idle();
        chk("fill_count_after", 64'(bus.count), 64'(0));

        // keep=1 replay of two vectors, restarted in the first idle cycle.
        cycle(1'b1, vec_of(0), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, vec_of(1), 1'b0, 1'b0, 1'b0);
        rec_q.delete();
        g_rec = 1;
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        wait_done(40, done_at);
        g_rec = 0;
        seq1 = rec_q;
        chk("keep_done_edge1", 64'(done_at), 64'(7));
        chk("keep_count", 64'(bus.count), 64'(2));
        rec_q.delete();
        g_rec = 1;
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        wait_done(40, done_at);
        g_rec = 0;
        chk("keep_done_edge2", 64'(done_at), 64'(7));
        same = (seq1.size() == rec_q.size()) && (seq1.size() > 0);
        for (int i = 0; i < seq1.size() && i < rec_q.size(); i++)
            if (seq1[i] !== rec_q[i]) same = 0;
        chk("keep_replay", 64'(same), 64'(1));
        cycle(1'b1, vec_of(5), 1'b0, 1'b0, 1'b0);
        chk("keep_append_count", 64'(bus.count), 64'(3));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Start on an empty buffer is ignored.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("empty_start_busy", 64'(bus.busy), 64'(0));
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (g_done) seen = 1;
        end
        chk("empty_start_done", 64'(seen), 64'(0));

        // Write and start on the same edge with two stored: three vectors stream.
        cycle(1'b1, vec_of(0), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, vec_of(1), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, vec_of(2), 1'b1, 1'b0, 1'b0);
        wait_done(40, done_at);
        chk("same_cycle_done_edge", 64'(done_at), 64'(8));

        // clr after edge 3 of a four-vector stream.
        for (int k = 0; k < 4; k++) cycle(1'b1, vec_of(k), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr_valid", 64'(bus.a_valid), 64'(0));
        chk("clr_busy", 64'(bus.busy), 64'(0));
        chk("clr_count", 64'(bus.count), 64'(0));
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (g_done) seen = 1;
        end
        chk("clr_no_done", 64'(seen), 64'(0));

        // Asynchronous reset in the middle of a stream.
        for (int k = 0; k < 3; k++) cycle(1'b1, vec_of(k), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 700; i++) begin
            cycle(1'($urandom_range(0, 99) < 60),
                  VEC_W'({$urandom(), $urandom()}),
                  1'($urandom_range(0, 99) < 8),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
